// File: rtl/frame_uart_reader.sv
// frame_uart_reader: streams one buffered frame from RAM to a UART transmitter, one byte per handshake.
// Define FRAME_HEADER_EN to prefix every frame with the HDR0/HDR1 sync bytes.
module frame_uart_reader #(
  parameter int         DEPTH  = 5160,
  parameter int         ADDR_W = $clog2(5160),
  parameter logic [7:0] HDR0   = 8'hAA,
  parameter logic [7:0] HDR1   = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [7:0]        rData,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef FRAME_HEADER_EN
    HDR_A,
    HDR_B,
`endif
    READ,
    LATCH,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rAddr_q, rAddr_d;
  logic [7:0]        txData_q, txData_d;
  logic              txValid_q, txValid_d;
  logic              frameDone_q, frameDone_d;
  logic              overrun_q, overrun_d;
  logic              xfer;
  logic              lastByte;

  assign xfer     = txValid_q & tx_ready;
  assign lastByte = (rAddr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rAddr_q     <= '0;
      txData_q    <= 8'h00;
      txValid_q   <= 1'b0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rAddr_q     <= rAddr_d;
      txData_q    <= txData_d;
      txValid_q   <= txValid_d;
      frameDone_q <= frameDone_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
`ifdef FRAME_HEADER_EN
          state_d = HDR_A;
`else
          state_d = READ;
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      HDR_A: if (xfer) state_d = HDR_B;
      HDR_B: if (xfer) state_d = READ;
`endif
      READ:    state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND:    if (xfer) state_d = lastByte ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // READ holds the address one cycle so the RAM's registered read data is ready in LATCH
  always_comb begin
    rAddr_d     = rAddr_q;
    txData_d    = txData_q;
    txValid_d   = txValid_q;
    frameDone_d = 1'b0;
    overrun_d   = overrun_q | (frame_tick & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          rAddr_d = '0;
`ifdef FRAME_HEADER_EN
          txData_d  = HDR0;
          txValid_d = 1'b1;
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      HDR_A: if (xfer) txData_d = HDR1;
      HDR_B: if (xfer) txValid_d = 1'b0;
`endif
      READ: txValid_d = 1'b0;
      LATCH: begin
        txData_d  = rData;
        txValid_d = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          txValid_d = 1'b0;
          if (lastByte) begin
            frameDone_d = 1'b1;
          end else begin
            rAddr_d = rAddr_q + ADDR_W'(1);
          end
        end
      end
      DONE: rAddr_d = '0;
      default: ;
    endcase
  end

  assign rAddr      = rAddr_q;
  assign tx_data    = txData_q;
  assign tx_valid   = txValid_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frameDone_q;
  assign overrun    = overrun_q;

endmodule
